// File: rtl/vga_scan_ctrl_if.sv
// Pixel-source handshake between the VGA scan controller and the pattern source.
// The controller requests pixels and flags line/frame starts; the source returns colour one cycle later.
interface vga_scan_ctrl_if #(
    parameter int BITS_PER_COLOR = 4
);
    logic                        o_rd;
    logic                        o_newline;
    logic                        o_newframe;
    logic [3*BITS_PER_COLOR-1:0] i_pixel;

    modport master (
        output o_rd,
        output o_newline,
        output o_newframe,
        input  i_pixel
    );

    modport slave (
        input  o_rd,
        input  o_newline,
        input  o_newframe,
        output i_pixel
    );
endinterface

// File: rtl/vga_scan_ctrl.sv
// VGA raster scan controller: shadowed timing, pixel request and 2-stage sync/DE/colour pipeline.
// Optional VGA_SYNC_POLARITY_EN adds i_hpol/i_vpol for programmable sync polarity.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | scan stopped, counters held at 0, waiting for i_en
// ST_START | single cycle: load timing shadows, pulse newline/newframe
// ST_RUN   | scanning frames; i_en sampled only at frame wrap
module vga_scan_ctrl #(
    parameter int BITS_PER_COLOR = 4,
    parameter int HW             = 12,
    parameter int VW             = 12
) (
    input  logic                      i_pixclk,
    input  logic                      i_reset_n,
    input  logic                      i_en,
    input  logic [HW-1:0]             i_hm_width,
    input  logic [HW-1:0]             i_hm_porch,
    input  logic [HW-1:0]             i_hm_synch,
    input  logic [HW-1:0]             i_hm_raw,
    input  logic [VW-1:0]             i_vm_height,
    input  logic [VW-1:0]             i_vm_porch,
    input  logic [VW-1:0]             i_vm_synch,
    input  logic [VW-1:0]             i_vm_raw,
`ifdef VGA_SYNC_POLARITY_EN
    input  logic                      i_hpol,
    input  logic                      i_vpol,
`endif
    vga_scan_ctrl_if.master           src,
    output logic                      o_vga_hsync,
    output logic                      o_vga_vsync,
    output logic                      o_vga_de,
    output logic [BITS_PER_COLOR-1:0] o_vga_red,
    output logic [BITS_PER_COLOR-1:0] o_vga_green,
    output logic [BITS_PER_COLOR-1:0] o_vga_blue
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;

    logic [1:0]    state;
    logic [HW-1:0] hpos;
    logic [VW-1:0] vpos;
    logic [HW:0]   hpos_nx;
    logic [VW:0]   vpos_nx;

    logic [HW-1:0] h_width, h_porch, h_synch, h_raw;
    logic [VW-1:0] v_height, v_porch, v_synch, v_raw;

    logic line_end, frame_end, load_shadow;
    logic rd_now, hs_now, vs_now;
    logic rd_d1, hs_d1, vs_d1, hs_d2, vs_d2;

    assign hpos_nx = {1'b0, hpos} + {{HW{1'b0}}, 1'b1};
    assign vpos_nx = {1'b0, vpos} + {{VW{1'b0}}, 1'b1};

    // ">=" instead of "==" so a raw value of 0 still wraps every cycle rather than locking up
    assign line_end  = hpos_nx >= {1'b0, h_raw};
    assign frame_end = line_end && (vpos_nx >= {1'b0, v_raw});

    assign load_shadow = (state == ST_START) || ((state == ST_RUN) && frame_end);

    assign rd_now = (state == ST_RUN) && (hpos < h_width) && (vpos < v_height);
    assign hs_now = (state == ST_RUN) && (hpos >= h_porch) && (hpos < h_synch);
    assign vs_now = (state == ST_RUN) && (vpos >= v_porch) && (vpos < v_synch);

    assign src.o_rd       = rd_now;
    assign src.o_newline  = (state == ST_START) || ((state == ST_RUN) && line_end);
    assign src.o_newframe = (state == ST_START) || ((state == ST_RUN) && frame_end);

    always_ff @(posedge i_pixclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= ST_IDLE;
            hpos  <= '0;
            vpos  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    hpos <= '0;
                    vpos <= '0;
                    if (i_en) state <= ST_START;
                end
                ST_START: begin
                    hpos  <= '0;
                    vpos  <= '0;
                    state <= ST_RUN;
                end
                ST_RUN: begin
                    if (line_end) begin
                        hpos <= '0;
                        if (frame_end) begin
                            vpos <= '0;
                            if (!i_en) state <= ST_IDLE;
                        end else begin
                            vpos <= vpos_nx[VW-1:0];
                        end
                    end else begin
                        hpos <= hpos_nx[HW-1:0];
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_pixclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            h_width  <= '0;
            h_porch  <= '0;
            h_synch  <= '0;
            h_raw    <= '0;
            v_height <= '0;
            v_porch  <= '0;
            v_synch  <= '0;
            v_raw    <= '0;
        end else if (load_shadow) begin
            h_width  <= i_hm_width;
            h_porch  <= i_hm_porch;
            h_synch  <= i_hm_synch;
            h_raw    <= i_hm_raw;
            v_height <= i_vm_height;
            v_porch  <= i_vm_porch;
            v_synch  <= i_vm_synch;
            v_raw    <= i_vm_raw;
        end
    end

    // Stage 1 lines up with the source returning i_pixel; stage 2 drives the pins
    always_ff @(posedge i_pixclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rd_d1       <= 1'b0;
            hs_d1       <= 1'b0;
            vs_d1       <= 1'b0;
            o_vga_de    <= 1'b0;
            hs_d2       <= 1'b0;
            vs_d2       <= 1'b0;
            o_vga_red   <= '0;
            o_vga_green <= '0;
            o_vga_blue  <= '0;
        end else begin
            rd_d1    <= rd_now;
            hs_d1    <= hs_now;
            vs_d1    <= vs_now;
            o_vga_de <= rd_d1;
            hs_d2    <= hs_d1;
            vs_d2    <= vs_d1;
            if (rd_d1) begin
                {o_vga_red, o_vga_green, o_vga_blue} <= src.i_pixel;
            end else begin
                o_vga_red   <= '0;
                o_vga_green <= '0;
                o_vga_blue  <= '0;
            end
        end
    end

`ifdef VGA_SYNC_POLARITY_EN
    logic hpol_sh, vpol_sh, hpol_use, vpol_use;

    always_ff @(posedge i_pixclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            hpol_sh <= 1'b0;
            vpol_sh <= 1'b0;
        end else if (load_shadow) begin
            hpol_sh <= i_hpol;
            vpol_sh <= i_vpol;
        end
    end

    // No latched polarity exists while idle/in reset, so the live input sets the inactive level
    assign hpol_use    = (state == ST_IDLE) ? i_hpol : hpol_sh;
    assign vpol_use    = (state == ST_IDLE) ? i_vpol : vpol_sh;
    assign o_vga_hsync = hs_d2 ? hpol_use : ~hpol_use;
    assign o_vga_vsync = vs_d2 ? vpol_use : ~vpol_use;
`else
    assign o_vga_hsync = ~hs_d2;
    assign o_vga_vsync = ~vs_d2;
`endif

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Self-checking bench for vga_scan_ctrl: cycle-level raster model, timing table, corner sequences.
// Builds with or without VGA_SYNC_POLARITY_EN (polarity held at active-low here).
module tb_vga_scan_ctrl;
    localparam int BPC = 4;

    logic        i_pixclk  = 1'b0;
    logic        i_reset_n = 1'b0;
    logic        i_en      = 1'b0;
    logic [11:0] i_hm_width = 12'd8, i_hm_porch = 12'd10, i_hm_synch = 12'd12, i_hm_raw = 12'd16;
    logic [11:0] i_vm_height = 12'd4, i_vm_porch = 12'd5, i_vm_synch = 12'd6, i_vm_raw = 12'd8;
    logic        hpol = 1'b0, vpol = 1'b0;
    logic        o_vga_hsync, o_vga_vsync, o_vga_de;
    logic [3:0]  o_vga_red, o_vga_green, o_vga_blue;

    int total = 0;
    int bad   = 0;

    vga_scan_ctrl_if #(.BITS_PER_COLOR(BPC)) src_if ();

    vga_scan_ctrl #(.BITS_PER_COLOR(BPC), .HW(12), .VW(12)) dut (
        .i_pixclk    (i_pixclk),
        .i_reset_n   (i_reset_n),
        .i_en        (i_en),
        .i_hm_width  (i_hm_width),
        .i_hm_porch  (i_hm_porch),
        .i_hm_synch  (i_hm_synch),
        .i_hm_raw    (i_hm_raw),
        .i_vm_height (i_vm_height),
        .i_vm_porch  (i_vm_porch),
        .i_vm_synch  (i_vm_synch),
        .i_vm_raw    (i_vm_raw),
`ifdef VGA_SYNC_POLARITY_EN
        .i_hpol      (hpol),
        .i_vpol      (vpol),
`endif
        .src         (src_if),
        .o_vga_hsync (o_vga_hsync),
        .o_vga_vsync (o_vga_vsync),
        .o_vga_de    (o_vga_de),
        .o_vga_red   (o_vga_red),
        .o_vga_green (o_vga_green),
        .o_vga_blue  (o_vga_blue)
    );

    always #5 i_pixclk = ~i_pixclk;

    // Reference model: mode 0 stopped, 1 start cycle, 2 scanning with t = cycles since frame start
    int          mode;
    int          t;
    int          sh [8];
    bit          sh_hp, sh_vp;
    bit          rdh [2];
    bit          hsh [2];
    bit          vsh [2];
    logic [11:0] pix_prev;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mode = 0; t = 0;
        for (int i = 0; i < 2; i++) begin rdh[i] = 0; hsh[i] = 0; vsh[i] = 0; end
        pix_prev = '0;
    endtask

    task automatic latch_sh();
        sh[0] = int'(i_hm_width);  sh[1] = int'(i_hm_porch); sh[2] = int'(i_hm_synch); sh[3] = int'(i_hm_raw);
        sh[4] = int'(i_vm_height); sh[5] = int'(i_vm_porch); sh[6] = int'(i_vm_synch); sh[7] = int'(i_vm_raw);
        sh_hp = hpol; sh_vp = vpol;
    endtask

    function automatic void cur(output bit rd, output bit nl, output bit nf, output bit hs, output bit vs);
        int h, v;
        rd = 0; nl = 0; nf = 0; hs = 0; vs = 0;
        if (mode == 1) begin
            nl = 1; nf = 1;
        end else if (mode == 2) begin
            h  = t % sh[3];
            v  = t / sh[3];
            rd = (h < sh[0]) && (v < sh[4]);
            nl = (h == sh[3] - 1);
            nf = nl && (v == sh[7] - 1);
            hs = (h >= sh[1]) && (h < sh[2]);
            vs = (v >= sh[5]) && (v < sh[6]);
        end
    endfunction

    task automatic check_cycle();
        bit rd, nl, nf, hs, vs, hp, vp;
        cur(rd, nl, nf, hs, vs);
        hp = (mode == 0) ? hpol : sh_hp;
        vp = (mode == 0) ? vpol : sh_vp;
        chk("rd", src_if.o_rd, rd);
        chk("newline", src_if.o_newline, nl);
        chk("newframe", src_if.o_newframe, nf);
        chk("de", o_vga_de, rdh[1]);
        chk("hsync", o_vga_hsync, hsh[1] ? hp : !hp);
        chk("vsync", o_vga_vsync, vsh[1] ? vp : !vp);
        chk("rgb", {o_vga_red, o_vga_green, o_vga_blue}, rdh[1] ? pix_prev : 12'h000);
    endtask

    task automatic tick();
        bit rd, nl, nf, hs, vs;
        cur(rd, nl, nf, hs, vs);
        rdh[1] = rdh[0]; rdh[0] = rd;
        hsh[1] = hsh[0]; hsh[0] = hs;
        vsh[1] = vsh[0]; vsh[0] = vs;
        pix_prev = src_if.i_pixel;
        if (mode == 0) begin
            if (i_en) mode = 1;
        end else if (mode == 1) begin
            latch_sh(); t = 0; mode = 2;
        end else begin
            t++;
            if (t == sh[3] * sh[7]) begin
                latch_sh(); t = 0;
                if (!i_en) mode = 0;
            end
        end
        @(posedge i_pixclk);
        @(negedge i_pixclk);
        check_cycle();
    endtask

    task automatic set_timing(input int hw, input int hp, input int hs, input int hr,
                              input int vh, input int vp, input int vs, input int vr);
        i_hm_width = 12'(hw);  i_hm_porch = 12'(hp); i_hm_synch = 12'(hs); i_hm_raw = 12'(hr);
        i_vm_height = 12'(vh); i_vm_porch = 12'(vp); i_vm_synch = 12'(vs); i_vm_raw = 12'(vr);
    endtask

    typedef struct {
        int hw, hp, hs, hr, vh, vp, vs, vr;
        int per, rds, hlow, vlow;
    } vec_t;

    vec_t vt [4];
    int   n_nf, per, rdc, hl, vl, a5c, guard, cyc, pulses, cnt;
    bit   seen;

    initial begin
        vt[0] = '{8, 10, 12, 16, 4, 5, 6, 8, 128, 32, 16, 16};
        vt[1] = '{6, 7, 9, 10, 3, 4, 5, 6, 60, 18, 12, 10};
        vt[2] = '{4, 5, 8, 8, 2, 3, 5, 5, 40, 8, 15, 16};
        vt[3] = '{1, 2, 3, 3, 1, 2, 3, 3, 9, 1, 3, 3};

        model_reset();
        latch_sh();
        src_if.i_pixel = 12'h000;
        repeat (3) @(negedge i_pixclk);
        check_cycle();
        chk("rst_hsync", o_vga_hsync, 1'b1);
        chk("rst_vsync", o_vga_vsync, 1'b1);
        i_reset_n = 1'b1;
        tick(); tick();
        chk("idle_no_frame", src_if.o_newframe, 1'b0);

        // Timing table: measure steady-state frame between the 2nd and 3rd newframe pulses
        src_if.i_pixel = 12'hA5C;
        for (int i = 0; i < 4; i++) begin
            set_timing(vt[i].hw, vt[i].hp, vt[i].hs, vt[i].hr, vt[i].vh, vt[i].vp, vt[i].vs, vt[i].vr);
            i_en = 1'b1;
            tick();
            chk("start_newline", src_if.o_newline, 1'b1);
            chk("start_newframe", src_if.o_newframe, 1'b1);
            chk("start_rd", src_if.o_rd, 1'b0);
            n_nf = 1; per = 0; rdc = 0; hl = 0; vl = 0; a5c = 0; guard = 0;
            while (n_nf < 3 && guard < 2000) begin
                tick();
                guard++;
                if (n_nf == 2) begin
                    per++;
                    rdc += int'(src_if.o_rd);
                    hl  += int'(!o_vga_hsync);
                    vl  += int'(!o_vga_vsync);
                    a5c += int'(o_vga_de && ({o_vga_red, o_vga_green, o_vga_blue} == 12'hA5C));
                end
                if (src_if.o_newframe) n_nf++;
            end
            chk("tbl_frames_seen", n_nf, 3);
            chk("tbl_period", per, vt[i].per);
            chk("tbl_rd_count", rdc, vt[i].rds);
            chk("tbl_hsync_low", hl, vt[i].hlow);
            chk("tbl_vsync_low", vl, vt[i].vlow);
            chk("tbl_colour_de", a5c, vt[i].rds);
            i_en = 1'b0;
            repeat (vt[i].per * 2 + 6) tick();
            chk("tbl_idle_de", o_vga_de, 1'b0);
        end

        // Width changed mid-frame takes effect only at the next frame
        set_timing(8, 10, 12, 16, 4, 5, 6, 8);
        i_en = 1'b1;
        tick();
        rdc = 0;
        for (int c = 0; c < 128; c++) begin
            if (c == 40) i_hm_width = 12'd6;
            tick();
            rdc += int'(src_if.o_rd);
        end
        chk("wchg_frame_end", src_if.o_newframe, 1'b1);
        chk("wchg_rd_old", rdc, 32);
        rdc = 0;
        repeat (128) begin tick(); rdc += int'(src_if.o_rd); end
        chk("wchg_rd_new", rdc, 24);
        i_en = 1'b0;
        repeat (140) tick();
        i_hm_width = 12'd8;

        // Enable dropped on line 1: frame still runs to 128 cycles, then silence
        i_en = 1'b1;
        tick();
        cyc = 0; seen = 0;
        repeat (20) begin tick(); cyc++; end
        i_en = 1'b0;
        while (!seen && cyc < 400) begin
            tick(); cyc++;
            if (src_if.o_newframe) seen = 1;
        end
        chk("drop_frame_len", cyc, 128);
        pulses = 0;
        repeat (40) begin
            tick();
            pulses += int'(src_if.o_newframe) + int'(src_if.o_newline) + int'(src_if.o_rd) + int'(o_vga_de);
        end
        chk("drop_idle_pulses", pulses, 0);

        // Asynchronous reset mid-line while DE is high
        i_en = 1'b1;
        tick();
        repeat (37) tick();
        chk("pre_rst_de", o_vga_de, 1'b1);
        #2 i_reset_n = 1'b0;
        #1;
        chk("arst_rd", src_if.o_rd, 1'b0);
        chk("arst_newline", src_if.o_newline, 1'b0);
        chk("arst_de", o_vga_de, 1'b0);
        chk("arst_hsync", o_vga_hsync, 1'b1);
        chk("arst_vsync", o_vga_vsync, 1'b1);
        chk("arst_rgb", {o_vga_red, o_vga_green, o_vga_blue}, 12'h000);
        model_reset();
        @(negedge i_pixclk);
        check_cycle();
        i_reset_n = 1'b1;
        tick();
        chk("post_rst_start", src_if.o_newframe, 1'b1);

        // Randomised run with occasional timing and enable changes
        cnt = 0;
        for (int c = 0; c < 3000; c++) begin
            src_if.i_pixel = 12'($urandom);
            if ($urandom_range(0, 199) == 0) begin
                int w, p, s, vh, vp, vs;
                w  = $urandom_range(1, 6);  p  = w + $urandom_range(1, 3);  s  = p + $urandom_range(1, 3);
                vh = $urandom_range(1, 4);  vp = vh + $urandom_range(1, 2); vs = vp + $urandom_range(1, 2);
                set_timing(w, p, s, s + $urandom_range(0, 3), vh, vp, vs, vs + $urandom_range(0, 2));
            end
            if ($urandom_range(0, 299) == 0) i_en = ~i_en;
            tick();
            cnt += int'(src_if.o_rd);
        end
        chk("rand_some_reads", cnt > 0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
